// File: rtl/peasant_pkg.sv
// Shared types for the shift-and-add multiplier.
// Holds the controller state encoding.
package peasant_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } peasant_state_e;

endpackage

// File: rtl/abs_n.sv
// Conditional two's-complement negate.
// Serves both operand magnitude and result sign correction.
module abs_n #(
    parameter int N = 16
) (
    input  logic         neg_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    always_comb begin
        q_o = d_i;
        if (neg_i) begin
            q_o = ~d_i + N'(1);
        end
    end

endmodule

// File: rtl/peasant_mul_hs.sv
// Sequential shift-and-add multiplier with start/done handshake,
// signed/unsigned mode, MAC accumulate and early termination.
module peasant_mul_hs
    import peasant_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           signed_i,
    input  logic           acc_i,
    input  logic [N-1:0]   data0_i,
    input  logic [N-1:0]   data1_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*N-1:0] y_o
);

    peasant_state_e state_q;
    peasant_state_e state_d;

    logic [N-1:0]   mplier_q;
    logic [2*N-1:0] mcand_q;
    logic [2*N-1:0] prod_q;
    logic           neg_q;
    logic           acc_q;
    logic           done_q;
    logic [2*N-1:0] y_q;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] fix_r;
    logic           mplier_zero;
    logic           load;
    logic           step;
    logic           fin;

    // Magnitudes only differ from the raw operands in signed mode.
    abs_n #(.N(N)) u_abs_a (
        .neg_i (signed_i & data0_i[N-1]),
        .d_i   (data0_i),
        .q_o   (a_mag)
    );

    abs_n #(.N(N)) u_abs_b (
        .neg_i (signed_i & data1_i[N-1]),
        .d_i   (data1_i),
        .q_o   (b_mag)
    );

    abs_n #(.N(2*N)) u_fix (
        .neg_i (neg_q),
        .d_i   (prod_q),
        .q_o   (fix_r)
    );

    assign mplier_zero = (mplier_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mplier_zero) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        fin    = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = start_i;
            end
            RUN: begin
                busy_o = 1'b1;
                step   = ~mplier_zero;
            end
            FIX: begin
                busy_o = 1'b1;
                fin    = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // Operand/product registers: cleared on reset, loaded on accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mplier_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            acc_q    <= 1'b0;
        end else if (load) begin
            mplier_q <= a_mag;
            mcand_q  <= {{N{1'b0}}, b_mag};
            prod_q   <= '0;
            neg_q    <= signed_i & (data0_i[N-1] ^ data1_i[N-1]);
            acc_q    <= acc_i;
        end else if (step) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    // Result register moves only on the edge that raises done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
            y_q    <= '0;
        end else begin
            done_q <= fin;
            if (fin) begin
                y_q <= acc_q ? (y_q + fix_r) : fix_r;
            end
        end
    end

    assign done_o = done_q;
    assign y_o    = y_q;

endmodule

// File: tb/tb_peasant_mul_hs.sv
// Self-checking bench for peasant_mul_hs: directed and random
// operations checked against an arithmetic reference model.
module tb_peasant_mul_hs;

    localparam int N = 16;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic           signed_i = 1'b0;
    logic           acc_i = 1'b0;
    logic [N-1:0]   data0_i = '0;
    logic [N-1:0]   data1_i = '0;
    logic           busy_o;
    logic           done_o;
    logic [2*N-1:0] y_o;

    int total = 0;
    int bad = 0;
    logic [2*N-1:0] yexp = '0;

    peasant_mul_hs #(.N(N)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .signed_i (signed_i),
        .acc_i    (acc_i),
        .data0_i  (data0_i),
        .data1_i  (data1_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .y_o      (y_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: drive start, follow it to done, check everything.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic sg, input logic ac,
                          input logic poke);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] prod;
        logic [31:0] y_before;
        logic [15:0] mag;
        int k;
        int lat;
        int busy_n;
        bit seen;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        if (sg) prod = 32'(sa * sb);
        else prod = {16'h0, a} * {16'h0, b};
        mag = (sg && a[15]) ? (16'h0 - a) : a;
        k = 0;
        for (int i = 0; i < 16; i++) if (mag[i]) k = i + 1;
        y_before = yexp;
        yexp = ac ? (yexp + prod) : prod;

        data0_i = a;
        data1_i = b;
        signed_i = sg;
        acc_i = ac;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        data0_i = 16'($urandom);
        data1_i = 16'($urandom);
        signed_i = 1'($urandom);
        acc_i = 1'($urandom);
        lat = -1;
        busy_n = 0;
        seen = 0;
        for (int j = 0; j <= N + 4 && !seen; j++) begin
            if (j > 0) begin
                @(posedge clk_i);
                #1;
                start_i = 1'b0;
            end
            if (done_o) begin
                seen = 1;
                lat = j;
            end else begin
                if (busy_o) busy_n++;
                chk("y_hold", y_o, y_before);
                if (poke && j == 1) start_i = 1'b1;
            end
        end
        start_i = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(k + 2));
        chk("busy_cycles", 32'(busy_n), 32'(k + 2));
        chk("busy_at_done", 32'(busy_o), 32'd0);
        chk("y_result", y_o, yexp);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_y", y_o, 32'h0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        run_op(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("tp_5x3", y_o, 32'h0000000F);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("tp_ffff_sq", y_o, 32'hFFFE0001);
        run_op(16'hFFFD, 16'h0007, 1'b1, 1'b0, 1'b0);
        chk("tp_m3x7", y_o, 32'hFFFFFFEB);
        run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        chk("tp_min_sq", y_o, 32'h40000000);
        run_op(16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("tp_zero", y_o, 32'h0);
        run_op(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1);
        run_op(16'h0002, 16'h0002, 1'b0, 1'b1, 1'b1);
        chk("tp_mac", y_o, 32'h00000013);
        run_op(16'h8000, 16'h0003, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a long run.
        data0_i = 16'hFFFF;
        data1_i = 16'hFFFF;
        signed_i = 1'b0;
        acc_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_y", y_o, 32'h0);
        chk("midrst_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        yexp = '0;
        begin
            int dones;
            dones = 0;
            repeat (20) begin
                @(posedge clk_i);
                #1;
                if (done_o) dones++;
            end
            chk("midrst_no_done", 32'(dones), 32'd0);
        end
        run_op(16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("tp_after_rst", y_o, 32'h9);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom) >> $urandom_range(0, 15);
            rb = 16'($urandom);
            run_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
